// File: rtl/snax_hwpe_job_regs_pkg.sv
// Shared definitions for the HWPE job register file.
// Holds the register word offsets, the STATUS bit positions and the job FSM state enum.
package snax_hwpe_job_regs_pkg;

  // Word offsets (byte address >> 2)
  localparam int unsigned RegTrigger = 0;
  localparam int unsigned RegStatus  = 1;
  localparam int unsigned RegClear   = 2;
  localparam int unsigned RegJobBase = 3;

  // STATUS layout
  localparam int unsigned StatusBusyBit    = 0;
  localparam int unsigned StatusPendingBit = 1;
  localparam int unsigned StatusCntLsb     = 16;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/snax_hwpe_job_regs_job_slot.sv
// NumJobRegs x 32-bit job register bank with load enable and synchronous clear.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : zero the bank (wins over load_i)
//   load_i       : capture data_i
//   data_i       : next bank contents, register k at [32k +: 32]
//   data_o       : current bank contents
module snax_hwpe_job_slot #(
  parameter int unsigned NumJobRegs = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      load_i,
  input  logic [32*NumJobRegs-1:0]  data_i,
  output logic [32*NumJobRegs-1:0]  data_o
);

  logic [32*NumJobRegs-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (load_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/snax_hwpe_job_regs.sv
// Memory-mapped job register file terminating a 32-bit HWPE peripheral port.
// Triple-buffered job registers: shadow (software-visible), pending (queued job) and
// active (driven to the datapath). A start/done handshake sequences jobs.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   periph_*                : peripheral request/grant and 1-cycle read response with ID echo
//   start_o                 : one-cycle pulse, job_o already valid in that cycle
//   job_o                   : active job registers, register k at [32k +: 32]
//   done_i                  : one-cycle job completion pulse
module snax_hwpe_job_regs
  import snax_hwpe_job_regs_pkg::*;
#(
  parameter int unsigned NumJobRegs = 4,
  parameter int unsigned IdWidth    = 5,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      periph_req_i,
  output logic                      periph_gnt_o,
  input  logic [31:0]               periph_add_i,
  input  logic                      periph_wen_i,
  input  logic [3:0]                periph_be_i,
  input  logic [31:0]               periph_data_i,
  input  logic [IdWidth-1:0]        periph_id_i,
  output logic                      periph_r_valid_o,
  output logic [31:0]               periph_r_data_o,
  output logic [IdWidth-1:0]        periph_r_id_o,
  output logic                      start_o,
  output logic [32*NumJobRegs-1:0]  job_o,
  input  logic                      done_i
);

  localparam int unsigned JobW = 32 * NumJobRegs;

  logic [7:0] word_idx;
  logic       is_trigger, is_clear, is_status;
  logic       stall, wr_go, rd_go, trig, clr;

  state_e               state_d, state_q;
  logic                 pending_d, pending_q;
  logic [CntWidth-1:0]  cnt_d, cnt_q;
  logic                 start_d, start_q;
  logic [JobW-1:0]      shadow_d, shadow_q;
  logic [JobW-1:0]      pend_data, act_data, act_src;
  logic                 act_load, act_from_pend, pend_load;
  logic [31:0]          status_w, rdata;
  logic                 r_valid_d, r_valid_q;
  logic [31:0]          r_data_d, r_data_q;
  logic [IdWidth-1:0]   r_id_d, r_id_q;

  // Address bits outside the word index alias onto the same map.
  logic unused_add;
  assign unused_add = ^{periph_add_i[31:10], periph_add_i[1:0]};

  assign word_idx   = periph_add_i[9:2];
  assign is_trigger = (word_idx == 8'(RegTrigger));
  assign is_status  = (word_idx == 8'(RegStatus));
  assign is_clear   = (word_idx == 8'(RegClear));

  // A TRIGGER with the pending slot occupied waits for done_i to free it.
  assign stall        = periph_req_i & ~periph_wen_i & is_trigger & (state_q == StRun) & pending_q;
  assign periph_gnt_o = periph_req_i & ~stall;
  assign wr_go        = periph_gnt_o & ~periph_wen_i;
  assign rd_go        = periph_gnt_o & periph_wen_i;
  assign trig         = wr_go & is_trigger;
  assign clr          = wr_go & is_clear;

  // Job sequencing
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    start_d       = 1'b0;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trig) begin
          act_load = 1'b1;
          start_d  = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (done_i) begin
          cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end
        // trig here implies pending_q == 0 (otherwise it would have stalled)
        if (trig) begin
          if (done_i) begin
            // Trigger then done: the new job skips the pending slot.
            act_load = 1'b1;
            start_d  = 1'b1;
          end else begin
            pend_load = 1'b1;
            pending_d = 1'b1;
          end
        end else if (done_i) begin
          if (pending_q) begin
            act_load      = 1'b1;
            act_from_pend = 1'b1;
            pending_d     = 1'b0;
            start_d       = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear wins for the counter; state transitions above already used the old pending flag.
    if (clr) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end
  end

  // Shadow bank with byte-enable writes
  always_comb begin
    shadow_d = shadow_q;
    if (clr) begin
      shadow_d = '0;
    end else if (wr_go) begin
      for (int unsigned k = 0; k < NumJobRegs; k++) begin
        if (word_idx == 8'(RegJobBase + k)) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (periph_be_i[b]) begin
              shadow_d[32*k + 8*b +: 8] = periph_data_i[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read mux
  always_comb begin
    status_w                   = '0;
    status_w[StatusBusyBit]    = (state_q == StRun);
    status_w[StatusPendingBit] = pending_q;
    status_w[StatusCntLsb +: CntWidth] = cnt_q;

    rdata = '0;
    if (is_status) begin
      rdata = status_w;
    end
    for (int unsigned k = 0; k < NumJobRegs; k++) begin
      if (word_idx == 8'(RegJobBase + k)) begin
        rdata = shadow_q[32*k +: 32];
      end
    end

    r_valid_d = rd_go;
    r_data_d  = rd_go ? rdata : '0;
    r_id_d    = rd_go ? periph_id_i : '0;
  end

  assign act_src = act_from_pend ? pend_data : shadow_q;

  snax_hwpe_job_slot #(
    .NumJobRegs(NumJobRegs)
  ) i_pending (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .load_i(pend_load),
    .data_i(shadow_q),
    .data_o(pend_data)
  );

  snax_hwpe_job_slot #(
    .NumJobRegs(NumJobRegs)
  ) i_active (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .load_i(act_load),
    .data_i(act_src),
    .data_o(act_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      shadow_q  <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      shadow_q  <= shadow_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_id_q    <= r_id_d;
    end
  end

  assign start_o          = start_q;
  assign job_o            = act_data;
  assign periph_r_valid_o = r_valid_q;
  assign periph_r_data_o  = r_data_q;
  assign periph_r_id_o    = r_id_q;

endmodule

// File: tb/tb_snax_hwpe_job_regs.sv
// Directed bench for snax_hwpe_job_regs: reset, byte enables, trigger/done sequencing,
// pending stall, simultaneous done+trigger, clear, counter wrap and mid-job reset.
module tb_snax_hwpe_job_regs;

  localparam logic [31:0] ATrig   = 32'h00;
  localparam logic [31:0] AStatus = 32'h04;
  localparam logic [31:0] AClear  = 32'h08;
  localparam logic [31:0] AJob0   = 32'h0C;
  localparam logic [31:0] AJob1   = 32'h10;
  localparam logic [31:0] AJob2   = 32'h14;
  localparam logic [31:0] AJob3   = 32'h18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic         gnt;
  logic [31:0]  add = '0;
  logic         wen = 1'b0;
  logic [3:0]   be = '0;
  logic [31:0]  wdata = '0;
  logic [4:0]   id = '0;
  logic         r_valid;
  logic [31:0]  r_data;
  logic [4:0]   r_id;
  logic         start;
  logic [127:0] job;
  logic         done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snax_hwpe_job_regs #(
    .NumJobRegs(4),
    .IdWidth   (5),
    .CntWidth  (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .periph_req_i    (req),
    .periph_gnt_o    (gnt),
    .periph_add_i    (add),
    .periph_wen_i    (wen),
    .periph_be_i     (be),
    .periph_data_i   (wdata),
    .periph_id_i     (id),
    .periph_r_valid_o(r_valid),
    .periph_r_data_o (r_data),
    .periph_r_id_o   (r_id),
    .start_o         (start),
    .job_o           (job),
    .done_i          (done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Granted write; returns at posedge+1 so start_o can be checked by the caller.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int n = 0;
    @(negedge clk);
    req = 1'b1; wen = 1'b0; add = a; wdata = d; be = b;
    #1;
    while (gnt !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_gnt", 128'(gnt), 128'(1'b1));
    @(posedge clk); #1;
    req = 1'b0; be = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [4:0] i,
                    input logic [31:0] exp);
    @(negedge clk);
    req = 1'b1; wen = 1'b1; add = a; id = i;
    @(posedge clk); #1;
    req = 1'b0;
    chk({tag, "_valid"}, 128'(r_valid), 128'(1'b1));
    chk({tag, "_id"}, 128'(r_id), 128'(i));
    chk(tag, 128'(r_data), 128'(exp));
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_start", 128'(start), 128'(0));
    chk("rst_job", job, 128'(0));
    chk("rst_rvalid", 128'(r_valid), 128'(0));
    chk("rst_gnt", 128'(gnt), 128'(0));

    rd("status_rst", AStatus, 5'd3, 32'h0);
    @(posedge clk); #1;
    chk("rvalid_one_cycle", 128'(r_valid), 128'(0));
    chk("start_idle", 128'(start), 128'(0));

    // Byte enables
    wr(AJob0, 32'hDEADBEEF, 4'b0011);
    rd("job0_be", AJob0, 5'd1, 32'h0000BEEF);

    // First job
    wr(AJob0, 32'd1, 4'hF);
    wr(AJob1, 32'd2, 4'hF);
    wr(AJob2, 32'd3, 4'hF);
    wr(AJob3, 32'd4, 4'hF);
    rd("job3_rd", AJob3, 5'd2, 32'd4);
    wr(ATrig, 32'h0, 4'hF);
    chk("start1", 128'(start), 128'(1));
    chk("job1", job, 128'h00000004_00000003_00000002_00000001);
    @(posedge clk); #1;
    chk("start1_fall", 128'(start), 128'(0));
    rd("status_busy", AStatus, 5'd4, 32'h0000_0001);
    pulse_done();
    rd("status_done1", AStatus, 5'd5, 32'h0001_0000);

    // Pending slot and stalled trigger
    wr(ATrig, 32'h0, 4'hF);
    wr(AJob0, 32'd9, 4'hF);
    wr(ATrig, 32'h0, 4'hF);
    rd("status_pend", AStatus, 5'd6, 32'h0001_0003);
    @(negedge clk);
    req = 1'b1; wen = 1'b0; add = ATrig; be = 4'hF;
    #1 chk("stall_gnt0", 128'(gnt), 128'(0));
    @(negedge clk);
    #1 chk("stall_gnt1", 128'(gnt), 128'(0));
    done = 1'b1;
    #1 chk("stall_gnt_done", 128'(gnt), 128'(0));
    @(posedge clk); #1;
    done = 1'b0;
    chk("start_pend", 128'(start), 128'(1));
    chk("job_pend", 128'(job[31:0]), 128'(32'd9));
    chk("stall_released", 128'(gnt), 128'(1));
    @(posedge clk); #1;
    req = 1'b0;
    rd("status_pend2", AStatus, 5'd7, 32'h0002_0003);
    pulse_done();
    rd("status_pend3", AStatus, 5'd8, 32'h0003_0001);
    pulse_done();
    rd("status_idle4", AStatus, 5'd9, 32'h0004_0000);

    // Simultaneous done and trigger with no pending job
    wr(AJob1, 32'h55, 4'hF);
    wr(ATrig, 32'h0, 4'hF);
    chk("job_j1", 128'(job[63:32]), 128'(32'h55));
    wr(AJob2, 32'h77, 4'hF);
    @(negedge clk);
    req = 1'b1; wen = 1'b0; add = ATrig; be = 4'hF; done = 1'b1;
    #1 chk("sim_gnt", 128'(gnt), 128'(1));
    @(posedge clk); #1;
    req = 1'b0; done = 1'b0;
    chk("sim_start", 128'(start), 128'(1));
    chk("sim_job", 128'(job[95:64]), 128'(32'h77));
    @(posedge clk); #1;
    chk("sim_start_single", 128'(start), 128'(0));
    rd("status_sim", AStatus, 5'd10, 32'h0005_0001);

    // Clear during a running job
    wr(AClear, 32'h0, 4'hF);
    rd("status_clr", AStatus, 5'd11, 32'h0000_0001);
    rd("job0_clr", AJob0, 5'd12, 32'h0);
    chk("job_kept", 128'(job[95:64]), 128'(32'h77));
    pulse_done();
    rd("status_clr_done", AStatus, 5'd13, 32'h0001_0000);

    // Counter wrap: trigger+done every cycle adds one completion each
    wr(ATrig, 32'h0, 4'hF);
    @(negedge clk);
    req = 1'b1; wen = 1'b0; add = ATrig; be = 4'hF; done = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    req = 1'b0; done = 1'b0;
    rd("status_wrap", AStatus, 5'd14, 32'h0000_0001);
    pulse_done();
    rd("status_after_wrap", AStatus, 5'd15, 32'h0001_0000);

    // done_i in IDLE is ignored
    pulse_done();
    rd("status_idle_done", AStatus, 5'd16, 32'h0001_0000);

    // Unmapped / read-zero / ignored writes
    rd("unmapped_rd", 32'h40, 5'd17, 32'h0);
    wr(AStatus, 32'hFFFF_FFFF, 4'hF);
    rd("status_ro", AStatus, 5'd18, 32'h0001_0000);
    rd("trig_rd0", ATrig, 5'd19, 32'h0);

    // Reset mid-job
    wr(AJob3, 32'hABCD, 4'hF);
    wr(ATrig, 32'h0, 4'hF);
    chk("job_pre_rst", 128'(job[127:96]), 128'(32'hABCD));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_job", job, 128'(0));
    chk("rst_mid_start", 128'(start), 128'(0));
    pulse_done();
    @(posedge clk); #1;
    chk("rst_done_start", 128'(start), 128'(0));
    rd("status_rst_mid", AStatus, 5'd20, 32'h0);
    rd("job3_rst_mid", AJob3, 5'd21, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snax_hwpe_job_regs.md
# snax_hwpe_job_regs

Memory-mapped register-file slave that terminates the 32-bit HWPE peripheral port driven by the Snitch-to-HWPE control bridge. It holds the accelerator job configuration, returns read data with ID echo, and sequences jobs into the MAC datapath through a start/done handshake. Job registers are triple-buffered (shadow, pending, active), so software can queue one job while another runs.

## Interface
- NumJobRegs, 4: number of 32-bit job configuration registers.
- IdWidth, 5: periph transaction ID width.
- CntWidth, 16: completed-job counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- periph_req_i  in  1  request valid.
- periph_gnt_o  out  1  request granted (combinational).
- periph_add_i  in  32  byte address.
- periph_wen_i  in  1  1 = read, 0 = write.
- periph_be_i  in  4  byte enables (writes only).
- periph_data_i  in  32  write data.
- periph_id_i  in  IdWidth  transaction ID.
- periph_r_valid_o  out  1  read response valid.
- periph_r_data_o  out  32  read data.
- periph_r_id_o  out  IdWidth  echoed ID.
- start_o  out  1  one-cycle job start pulse.
- job_o  out  32*NumJobRegs  active job registers; register k at bits [32k+31:32k].
- done_i  in  1  one-cycle job completion pulse from the datapath.

## Operation
- Word index = add[2+:8]. Map:
  - 0x00 TRIGGER (W; reads 0).
  - 0x04 STATUS (RO): bit0 busy, bit1 pending, [16+:CntWidth] done count.
  - 0x08 CLEAR (W).
  - 0x0C + 4k JOB[k] (RW shadow).
- Unmapped reads return 0. Unmapped writes are ignored. Writes to STATUS are ignored.
- JOB writes honour be per byte. JOB reads return the shadow value.
- FSM has two states, IDLE and RUN, plus a pending flag.
- TRIGGER write in IDLE: shadow → active; go to RUN.
- TRIGGER write in RUN with no pending: shadow → pending; pending=1.
- TRIGGER write in RUN with pending=1: not granted (periph_gnt_o=0) until the pending slot frees.
- done_i in RUN: counter += 1 (wraps at 2^CntWidth).
  - If pending: pending → active, pending=0, stay in RUN, issue a new start.
  - Else: go to IDLE.
- done_i in IDLE: ignored; counter unchanged.
- CLEAR write:
  - zeroes shadow, pending flag and counter;
  - running job is not aborted; FSM state unchanged;
  - active registers are untouched.
- All other requests are granted in the same cycle: periph_gnt_o = periph_req_i.

## Timing
- Reset values:
  - every output is 0;
  - all registers are 0;
  - state is IDLE, pending=0.
- Read data latency is 1 cycle. A granted read in cycle N gives r_valid=1, r_data and r_id in cycle N+1, held for exactly one cycle.
- Writes produce no response.
- Register updates are visible to a read granted in the following cycle.
- start_o rises in the cycle after the grant of TRIGGER (from IDLE) or after done_i (with pending). job_o already holds the new value in that cycle.
- Simultaneous done_i and granted TRIGGER, pending=0, in RUN: treat as TRIGGER then done. Shadow → active directly, start_o the next cycle, pending stays 0.
- Simultaneous done_i and CLEAR: the clear wins for the counter (result 0). State transitions still apply using pending before the clear.
- Reset asserted mid-job: everything returns to reset values next edge. A later done_i is ignored.

## Structure
- snax_hwpe_job_regs_pkg holds the register offsets, STATUS bit positions and the state enum.
- One natural sub-module: snax_hwpe_job_slot, a NumJobRegs×32 register bank with load enable and synchronous clear. It is instantiated for pending and active.
- The shadow bank is inline because of its byte-enable writes.

## Test plan
- Reset, then read STATUS id=3 → next cycle r_valid=1, r_data=0, r_id=3; start_o=0.
- Write JOB0=0xDEADBEEF with be=4'b0011, then read → 0x0000BEEF.
- Write JOB0..3=1,2,3,4, then TRIGGER → start_o one cycle later, job_o={4,3,2,1}, STATUS bit0=1. Then done_i → STATUS=0x00010000.
- While RUN: write JOB0=9, TRIGGER (granted, pending=1), second TRIGGER → gnt_o=0 until done_i. After done_i: start_o next cycle, job_o[31:0]=9, stalled TRIGGER then granted.
- done_i together with a TRIGGER grant, pending=0 → single start_o next cycle, pending stays 0, count+1.
- Run 2^16 jobs → counter wraps to 0. CLEAR during RUN → count 0, busy stays 1 until done_i.
